// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter: add/subtract a 0..9 step one digit per cycle,
// then commit the result with done and optional overflow/underflow pulses.
module bcd_score_counter #(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [3:0]            cmd_step,
  output logic [4*DIGITS-1:0]   num,
  output logic                  done,
  output logic                  ovf,
  output logic                  unf
);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

  state_t              r_state;
  logic [4*DIGITS-1:0] r_num;
  logic [4*DIGITS-1:0] r_shadow;
  logic [2:0]          r_idx;
  logic [3:0]          r_carry;
  logic                r_op;
  logic                r_done;
  logic                r_ovf;
  logic                r_unf;

  logic [3:0]          w_step;
  logic [3:0]          w_dig;
  logic [4:0]          w_sum;
  logic [3:0]          w_dig_next;
  logic                w_cout;

  // On a carry/borrow out of the top digit: wrapped value, or all-9s / all-0s clamp.
  function automatic logic [4*DIGITS-1:0] commit_value(
    input logic [4*DIGITS-1:0] wrapped,
    input logic                out_of_range,
    input logic                is_sub
  );
    if (!out_of_range || (WRAP != 0))
      return wrapped;
    else if (is_sub)
      return '0;
    else
      return {DIGITS{4'h9}};
  endfunction

  assign w_step = (cmd_step > 4'd9) ? 4'd9 : cmd_step;
  assign w_dig  = r_shadow[4*r_idx +: 4];
  assign w_sum  = {1'b0, w_dig} + {1'b0, r_carry};

  // Digit results are computed modulo 16; the true result always lands in 0..9.
  always_comb begin
    w_dig_next = w_dig;
    w_cout     = 1'b0;
    if (!r_op) begin
      if (w_sum > 5'd9) begin
        w_dig_next = w_dig + r_carry + 4'd6;
        w_cout     = 1'b1;
      end else begin
        w_dig_next = w_dig + r_carry;
      end
    end else begin
      if (w_dig >= r_carry) begin
        w_dig_next = w_dig - r_carry;
      end else begin
        w_dig_next = w_dig + 4'd10 - r_carry;
        w_cout     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_num    <= '0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_carry  <= '0;
      r_op     <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      if (clr) begin
        r_state  <= IDLE;
        r_num    <= '0;
        r_shadow <= '0;
        r_idx    <= '0;
        r_carry  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (cmd_valid) begin
              r_state  <= CALC;
              r_shadow <= r_num;
              r_idx    <= '0;
              r_carry  <= w_step;
              r_op     <= cmd_op;
            end
          end
          CALC: begin
            r_shadow[4*r_idx +: 4] <= w_dig_next;
            r_carry                <= {3'b000, w_cout};
            if (r_idx == LAST_IDX)
              r_state <= COMMIT;
            else
              r_idx <= r_idx + 3'd1;
          end
          COMMIT: begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_ovf   <= r_carry[0] & ~r_op;
            r_unf   <= r_carry[0] & r_op;
            r_num   <= commit_value(r_shadow, r_carry[0], r_op);
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign num       = r_num;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: doc/bcd_score_counter.md
BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD digits, legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = modulo-10^DIGITS wrap on overflow/underflow; 0 = saturate.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 clr  in  1  synchronous clear; highest priority below rst.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command; high only in IDLE.
REQ-008 cmd_op  in  1  0 = add, 1 = subtract.
REQ-009 cmd_step  in  4  step magnitude, BCD 0..9.
REQ-010 num  out  4*DIGITS  current score as packed 8421 BCD; digit 0 in bits [3:0].
REQ-011 done  out  1  one-cycle pulse when a command's result is committed to num.
REQ-012 ovf  out  1  one-cycle pulse, coincident with done, when an add carried out of the top digit.
REQ-013 unf  out  1  one-cycle pulse, coincident with done, when a subtract borrowed out of the top digit.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and COMMIT.
REQ-015 A command is accepted on the rising edge where cmd_valid && cmd_ready; cmd_op and cmd_step are latched then, and later input changes are ignored until the next acceptance.
REQ-016 A cmd_step value of 10..15 SHALL be treated as 9.
REQ-017 On acceptance the FSM SHALL:
- move IDLE -> CALC;
- copy num into a shadow register;
- set digit index to 0;
- set carry/borrow to the latched step.
REQ-018 Each CALC cycle processes one digit i, using c = carry/borrow:
- add: s = d + c; if s > 9 then d = s - 10 and c = 1, else d = s and c = 0.
- subtract: if d >= c then d = d - c and c = 0, else d = d + 10 - c and c = 1.
REQ-019 CALC SHALL take exactly DIGITS cycles regardless of early carry termination, then move to COMMIT.
REQ-020 In COMMIT the FSM SHALL write the shadow value to num, pulse done, and return to IDLE; num changes only in COMMIT.
REQ-021 Latency SHALL be fixed: a command accepted at edge T updates num, and pulses done, at edge T+DIGITS+1; cmd_ready is high again in the cycle after COMMIT.
REQ-022 If the final carry is 1 on an add:
- ovf SHALL pulse;
- WRAP=1 commits the wrapped value;
- WRAP=0 commits all digits = 9.
REQ-023 If the final borrow is 1 on a subtract:
- unf SHALL pulse;
- WRAP=1 commits the wrapped value;
- WRAP=0 commits all digits = 0.
REQ-024 A step of 0 SHALL complete the normal sequence with num unchanged, done pulsed, and no ovf/unf.
REQ-025 clr asserted in any state SHALL, on that edge:
- set num to 0;
- abort any in-flight command without done/ovf/unf;
- force IDLE.
REQ-026 When clr and an accepting cmd_valid occur on the same edge, the command SHALL be discarded.
REQ-027 done, ovf and unf SHALL be registered outputs, low in every cycle other than COMMIT.
REQ-028 Digits of num SHALL never hold values 10..15 after reset.

Reset
REQ-029 rst SHALL immediately, without a clock, force:
- num = 0, state = IDLE;
- done = ovf = unf = 0;
- shadow, index and carry cleared.
REQ-030 cmd_ready SHALL be 1 while rst is asserted and after its release; an in-flight command is lost with no pulses.

Verification (DIGITS=3)
REQ-031 rst; add 7, then add 5 -> num=0x012; each done exactly 4 cycles after acceptance; ovf=unf=0.
REQ-032 WRAP=1, num=0x999, add 2 -> num=0x001, ovf=1 for one cycle with done.
REQ-033 WRAP=0, num=0x998, add 5 -> num=0x999 with ovf; then from num=0x001, subtract 3 -> num=0x000 with unf.
REQ-034 num=0x100, subtract 1 -> num=0x099 (two-digit borrow ripple); step=12 from 0x000 adds 9 -> 0x009.
REQ-035 Accept add 9, assert clr in the second CALC cycle -> num=0x000 next edge, no done; cmd_ready=1 the following cycle.
REQ-036 Assert rst asynchronously between edges during CALC -> num=0x000 immediately, no done; a following add 1 yields 0x001.
